// File: rtl/decoder_seq_pkg.sv
// decoder_seq_pkg: shared state encoding and default select width for the burst sequencer
package decoder_seq_pkg;
    localparam int SEL_W_DEFAULT = 3;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/decoder_burst_sequencer.sv
// decoder_burst_sequencer: walks a downstream decoder select through a wrapping burst of lines
module decoder_burst_sequencer
    import decoder_seq_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_addr,
    input  logic [SEL_W-1:0] req_len,
    input  logic             hold,
    input  logic             abort,
    output logic [SEL_W-1:0] select,
    output logic             enable,
    output logic             done,
    output logic             aborted
);
    state_t           state;
    logic [SEL_W-1:0] addr;
    logic [SEL_W-1:0] cnt;
    logic             cut;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            cnt   <= '0;
            cut   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr  <= req_addr;
                    cnt   <= req_len;
                    cut   <= 1'b0;
                    state <= ACTIVE;
                end
                ACTIVE: if (abort) begin
                    cut   <= 1'b1;
                    state <= DONE;
                end else if (!hold) begin
                    if (cnt == '0) state <= DONE;
                    else begin
                        addr <= addr + 1'b1;
                        cnt  <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    cut   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // hold is the only input that reaches an output without a register
    always_comb begin
        req_ready = state == IDLE;
        enable    = state == ACTIVE && !hold;
        select    = addr;
        done      = state == DONE;
        aborted   = state == DONE && cut;
    end
endmodule

// File: tb/tb_decoder_burst_sequencer.sv
// tb_decoder_burst_sequencer: directed cycle-by-cycle checks of the sequencer driving a 3-to-8 decoder
module tb_decoder_burst_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_addr = '0;
    logic [2:0] req_len = '0;
    logic       hold = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] select;
    logic       enable;
    logic       done;
    logic       aborted;
    logic [7:0] dec;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    decoder_burst_sequencer #(.SEL_W(3)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .hold(hold), .abort(abort),
        .select(select), .enable(enable), .done(done), .aborted(aborted)
    );

    // downstream 3-to-8 decoder fed by select/enable
    assign dec = enable ? 8'(8'd1 << select) : 8'h00;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input logic v, input int a, input int l, input logic h, input logic ab);
        @(posedge clk);
        #2;
        req_valid = v;
        req_addr  = 3'(a);
        req_len   = 3'(l);
        hold      = h;
        abort     = ab;
        #1;
    endtask

    task automatic beat(input string t, input int s);
        chk({t, "_en"}, int'(enable), 1);
        chk({t, "_sel"}, int'(select), s);
        chk({t, "_dec"}, int'(dec), 1 << s);
        chk({t, "_rdy"}, int'(req_ready), 0);
    endtask

    task automatic stall(input string t, input int s);
        chk({t, "_en"}, int'(enable), 0);
        chk({t, "_sel"}, int'(select), s);
        chk({t, "_dec"}, int'(dec), 0);
    endtask

    task automatic fin(input string t, input int ab);
        chk({t, "_done"}, int'(done), 1);
        chk({t, "_abt"}, int'(aborted), ab);
        chk({t, "_en"}, int'(enable), 0);
        chk({t, "_dec"}, int'(dec), 0);
        chk({t, "_rdy"}, int'(req_ready), 0);
    endtask

    task automatic idle(input string t);
        chk({t, "_rdy"}, int'(req_ready), 1);
        chk({t, "_done"}, int'(done), 0);
        chk({t, "_abt"}, int'(aborted), 0);
        chk({t, "_en"}, int'(enable), 0);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0;
        idle("rst");
        chk("rst_sel", int'(select), 0);

        cyc(1, 3, 2, 0, 0);
        idle("b1_acc");
        cyc(0, 0, 0, 0, 0); beat("b1_0", 3);
        cyc(0, 0, 0, 0, 0); beat("b1_1", 4);
        cyc(0, 0, 0, 0, 0); beat("b1_2", 5);
        cyc(0, 0, 0, 0, 0); fin("b1_fin", 0);
        cyc(0, 0, 0, 0, 0); idle("b1_idle");

        cyc(1, 2, 5, 0, 0);
        cyc(0, 0, 0, 0, 0); beat("r_0", 2);
        cyc(0, 0, 0, 0, 0); beat("r_1", 3);
        cyc(0, 0, 0, 0, 0); beat("r_2", 4);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0;
        idle("r_after");
        chk("r_sel", int'(select), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            idle("r_quiet");
        end

        // abort alongside a request in IDLE must not block acceptance
        cyc(1, 6, 3, 0, 1);
        cyc(0, 0, 0, 0, 0); beat("w_0", 6);
        cyc(0, 0, 0, 0, 0); beat("w_1", 7);
        cyc(0, 0, 0, 0, 0); beat("w_2", 0);
        cyc(0, 0, 0, 0, 0); beat("w_3", 1);
        cyc(0, 0, 0, 0, 1); fin("w_fin", 0);
        chk("w_fin_sel", int'(select), 1);
        cyc(0, 0, 0, 0, 0); idle("w_idle");
        chk("w_idle_sel", int'(select), 1);

        cyc(1, 0, 4, 0, 0);
        cyc(0, 0, 0, 0, 0); beat("h_0", 0);
        cyc(0, 0, 0, 1, 0); stall("h_1", 1);
        cyc(0, 0, 0, 1, 0); stall("h_2", 1);
        cyc(0, 0, 0, 0, 0); beat("h_3", 1);
        cyc(0, 0, 0, 0, 0); beat("h_4", 2);
        cyc(0, 0, 0, 0, 0); beat("h_5", 3);
        cyc(0, 0, 0, 0, 0); beat("h_6", 4);
        cyc(0, 0, 0, 0, 0); fin("h_fin", 0);
        cyc(0, 0, 0, 0, 0); idle("h_idle");

        cyc(1, 1, 7, 0, 0);
        cyc(0, 0, 0, 0, 0); beat("a_0", 1);
        cyc(0, 0, 0, 0, 0); beat("a_1", 2);
        cyc(0, 0, 0, 1, 1); stall("a_2", 3);
        cyc(0, 0, 0, 0, 0); fin("a_fin", 1);
        chk("a_fin_sel", int'(select), 3);
        cyc(0, 0, 0, 0, 0); idle("a_idle");

        cyc(1, 5, 1, 0, 0);
        idle("bb_acc");
        cyc(1, 5, 1, 0, 0); beat("bb_0", 5);
        cyc(1, 5, 1, 0, 0); beat("bb_1", 6);
        cyc(1, 5, 1, 0, 0); fin("bb_fin", 0);
        cyc(1, 5, 1, 0, 0); idle("bb_idle");
        cyc(0, 0, 0, 0, 0); beat("bb2_0", 5);
        cyc(0, 0, 0, 0, 0); beat("bb2_1", 6);
        cyc(0, 0, 0, 0, 0); fin("bb2_fin", 0);
        cyc(0, 0, 0, 0, 0); idle("bb2_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
